ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
// PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same PS2_KBCLK/PS2_KBDAT pair the Keyboard receiver listens on.
// Drives both lines open-drain: inhibit, request-to-send, 11-bit frame, device ACK check.
// Sits beside Keyboard in the top level. Keyboard must ignore the bus while busy=1.
// PARAMETERS
// INHIBIT_CYCLES  5000    clk cycles that PS2 clock is held low before RTS (100 us at 50 MHz)
// TIMEOUT_CYCLES  750000  max clk cycles from RTS until ACK completes (15 ms at 50 MHz)
// FILTER_LEN      8       consecutive identical samples needed to accept a ps2_clk_in level change
// PORTS
// clk          in   1  system clock, 50 MHz
// rst          in   1  asynchronous, active-high reset
// tx_data      in   8  command byte; captured when tx_valid & tx_ready
// tx_valid     in   1  request to send tx_data
// tx_ready     out  1  1 in IDLE only
// busy         out  1  1 in every state except IDLE
// tx_done      out  1  one-cycle pulse: frame sent and ACK received
// tx_err       out  1  one-cycle pulse: ACK missing (data high) or timeout
// ps2_clk_in   in   1  raw PS2 clock pin level (async)
// ps2_dat_in   in   1  raw PS2 data pin level (async)
// ps2_clk_oe   out  1  1 = pull PS2 clock low; 0 = release (pull-up)
// ps2_dat_oe   out  1  1 = pull PS2 data low; 0 = release
// BEHAVIOUR
// - Reset (async): state IDLE; tx_ready=1; busy, tx_done, tx_err, both _oe = 0 (lines released at once, mid-frame included); counters and shift reg cleared.
// - Inputs: 2-flop synchronizers on both pins. The clock pin also passes the FILTER_LEN filter. fall = filtered clk 1->0, one-cycle strobe.
// - Frame: {start 0, d0..d7 LSB first, odd parity = ~^tx_data, stop 1}, then ACK (device drives data 0).
// - IDLE: on tx_valid & tx_ready, latch tx_data and parity, clear counters -> INHIBIT on the next cycle. tx_ready drops in the same edge.
// - INHIBIT: clk_oe=1, dat_oe=0. After INHIBIT_CYCLES cycles -> RTS.
// - RTS: dat_oe=1 (start bit), clk_oe=0 released on the same edge; timeout counter starts. On 1st fall -> DATA, bit index=0.
// - DATA: on each fall, dat_oe <= ~shift[0] and shift right. Data changes only while the clock is low. After the 8th fall (d7 driven) -> PARITY.
// - PARITY: on fall, dat_oe <= ~parity -> STOP.
// - STOP: on fall, dat_oe <= 0 (stop = 1 released) -> ACK.
// - ACK: on the next fall, sample synced ps2_dat_in. 0 -> WAIT_IDLE. 1 -> ERR.
// - WAIT_IDLE: wait until filtered clk=1 and synced dat=1, then tx_done=1 for 1 cycle -> IDLE.
// - ERR: both _oe=0, tx_err=1 for 1 cycle -> IDLE.
// - Timeout: counter runs RTS..WAIT_IDLE and saturates at TIMEOUT_CYCLES.
// - Reaching TIMEOUT_CYCLES in any of those states -> ERR, whatever fall does in the same cycle (timeout wins).
// - tx_valid while busy is ignored; no queueing. tx_data is sampled only at accept.
// - tx_done and tx_err never assert in the same cycle. Accept-to-IDLE fires exactly one of them.
// - Counter widths: $clog2 of the parameter, no wrap (saturate). Bit index is 3 bits, 0..7.
// - Outputs registered; _oe change only on clk edges (top ties pin = oe ? 1'b0 : 1'bz).
// TESTING
// Device model: clock 40 us half-period, starts 200 us after seeing clk released with data low. It samples data on rising edges and drives ACK low on the 11th clock.
// 1 send 0xED -> clk low >=5000 cycles; bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK 0 -> tx_done pulse once, tx_ready back to 1.
// 2 send 0xF4 -> parity 0 sampled by model; tx_done; tx_err stays 0.
// 3 send 0xFF with model never driving ACK -> tx_err pulse after 11th fall; both _oe=0.
// 4 send 0x00 with model never clocking -> tx_err exactly TIMEOUT_CYCLES after RTS entry; tx_done never asserted.
// 5 assert rst during DATA bit 4 -> clk_oe=dat_oe=0 without waiting for clk, tx_ready=1; next 0xF4 completes normally.
// 6 pulse tx_valid with 0x55 while busy during 0xED send -> model receives only 0xED; exactly one tx_done.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Handshake and open-drain pin bundle between ps2_host_tx and its environment.
// The slave side is the transmitter; the master side is the system/pin wrapper.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    input  tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    output tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame
// clocked by the device, then ACK check. Both PS/2 lines are driven open-drain via _oe.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus
);

  localparam int INH_W  = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  // Pin conditioning
  logic              clk_meta, clk_sync, dat_meta, dat_sync;
  logic              clk_filt, clk_filt_prev;
  logic [FILT_W-1:0] filt_cnt;
  logic              fall;

  // Datapath
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [2:0]       bit_idx_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;

  // Registered outputs and their next values
  logic tx_ready_q, busy_q, tx_done_q, tx_err_q, clk_oe_q, dat_oe_q;
  logic tx_ready_d, busy_d, tx_done_d, tx_err_d, clk_oe_d, dat_oe_d;

  logic accept, inh_done, tmo_active, tmo_hit;

  // Lines idle high, so synchronizers and filter reset to 1 to avoid a spurious fall.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta      <= 1'b1;
      clk_sync      <= 1'b1;
      dat_meta      <= 1'b1;
      dat_sync      <= 1'b1;
      clk_filt      <= 1'b1;
      clk_filt_prev <= 1'b1;
      filt_cnt      <= '0;
    end else begin
      clk_meta      <= bus.ps2_clk_in;
      clk_sync      <= clk_meta;
      dat_meta      <= bus.ps2_dat_in;
      dat_sync      <= dat_meta;
      clk_filt_prev <= clk_filt;
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_prev & ~clk_filt;

  assign accept     = (state_q == S_IDLE) && bus.tx_valid && tx_ready_q;
  assign inh_done   = (inh_cnt_q == INH_LAST);
  assign tmo_active = state_q inside {S_RTS, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE};
  assign tmo_hit    = tmo_active && (tmo_cnt_q >= TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else if (accept) begin
      shift_q   <= bus.tx_data;
      parity_q  <= ~^bus.tx_data;
      bit_idx_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      if (state_q == S_INHIBIT && !inh_done) inh_cnt_q <= inh_cnt_q + 1'b1;
      if (tmo_active && tmo_cnt_q != TMO_MAX) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      // The fall leaving RTS already puts d0 on the line; each DATA fall puts the next bit.
      if (fall && !tmo_hit) begin
        unique case (state_q)
          S_RTS: begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
          end
          S_DATA: begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (accept) state_d = S_INHIBIT;
      S_INHIBIT:   if (inh_done) state_d = S_RTS;
      S_RTS:       if (fall) state_d = S_DATA;
      S_DATA:      if (fall && bit_idx_q == 3'd6) state_d = S_PARITY;
      S_PARITY:    if (fall) state_d = S_STOP;
      S_STOP:      if (fall) state_d = S_ACK;
      S_ACK:       if (fall) state_d = dat_sync ? S_ERR : S_WAIT_IDLE;
      S_WAIT_IDLE: if (clk_filt && dat_sync) state_d = S_IDLE;
      S_ERR:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // A timeout overrides whatever the clock edge would have done this cycle.
    if (tmo_hit) state_d = S_ERR;
  end

  always_comb begin
    tx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    clk_oe_d   = (state_d == S_INHIBIT);
    tx_err_d   = (state_d == S_ERR);
    tx_done_d  = (state_q == S_WAIT_IDLE) && (state_d == S_IDLE);

    dat_oe_d = dat_oe_q;
    if (fall) begin
      unique case (state_q)
        S_RTS, S_DATA: dat_oe_d = ~shift_q[0];
        S_PARITY:      dat_oe_d = ~parity_q;
        S_STOP:        dat_oe_d = 1'b0;
        default:       ;
      endcase
    end
    unique case (state_d)
      S_IDLE, S_INHIBIT, S_ACK, S_WAIT_IDLE, S_ERR: dat_oe_d = 1'b0;
      S_RTS:                                        dat_oe_d = 1'b1;
      default:                                      ;
    endcase
  end

  assign bus.tx_ready   = tx_ready_q;
  assign bus.busy       = busy_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.tx_err     = tx_err_q;
  assign bus.ps2_clk_oe = clk_oe_q;
  assign bus.ps2_dat_oe = dat_oe_q;

  a_done_err_exclusive: assert property (@(posedge clk) disable iff (rst) !(tx_done_q && tx_err_q));
  a_ready_busy_comp:    assert property (@(posedge clk) disable iff (rst) (tx_ready_q != busy_q));
  a_clk_dat_not_both:   assert property (@(posedge clk) disable iff (rst) !(clk_oe_q && dat_oe_q));

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a scaled PS/2 device model clocks the frame, a scoreboard
// holds expected frame bits and outcomes, and monitors compare as the DUT produces them.
module tb_ps2_host_tx;
  localparam int INH       = 50;
  localparam int TMO       = 3000;
  localparam int FILT      = 8;
  localparam int HALF      = 40;
  localparam int START_DLY = 200;

  localparam logic [1:0] R_DONE = 2'b01;
  localparam logic [1:0] R_ERR  = 2'b10;

  typedef enum int {M_NORMAL, M_NO_ACK, M_SILENT} mode_e;

  logic clk;
  logic rst;
  logic dev_clk_low;
  logic dev_dat_low;

  ps2_host_tx_if bus ();

  assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low);
  assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FILT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  int          rts_cyc      = 0;
  int          done_cnt     = 0;
  int          err_cnt      = 0;
  int          dev_fall_cnt = 0;
  bit          dev_abort    = 1'b0;
  bit          tmo_armed    = 1'b0;
  bit          tmo_seen     = 1'b0;
  mode_e       dev_mode     = M_NORMAL;
  logic [9:0]  frame_q[$];
  logic [1:0]  res_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- device model ----------------
  task automatic dev_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rst) dev_abort = 1'b1;
    end
  endtask

  task automatic run_frame();
    logic [9:0] bits;
    bits         = '0;
    dev_abort    = 1'b0;
    dev_fall_cnt = 0;
    dev_wait(START_DLY);
    for (int i = 1; i <= 11 && !dev_abort; i++) begin
      dev_clk_low  = 1'b1;
      dev_fall_cnt = i;
      dev_wait(HALF);
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i-1] = bus.ps2_dat_in;
      if (i == 10 && dev_mode == M_NORMAL) dev_dat_low = 1'b1;
      if (i == 11) dev_dat_low = 1'b0;
      dev_wait(HALF);
    end
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    if (!dev_abort) begin
      if (frame_q.size() == 0) check("unexpected_frame", 32'(frame_q.size()), 32'd1);
      else                     check("frame_bits", 32'(bits), 32'(frame_q.pop_front()));
    end
  endtask

  initial begin : device
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && dev_mode != M_SILENT && bus.ps2_clk_in === 1'b1 && bus.ps2_dat_in === 1'b0)
        run_frame();
    end
  end

  // ---------------- monitors ----------------
  initial begin : pin_monitor
    int   inh_len;
    logic prev_oe;
    inh_len = 0;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        inh_len = 0;
        prev_oe = 1'b0;
      end else begin
        if (bus.ps2_clk_oe) begin
          inh_len++;
        end else if (prev_oe) begin
          rts_cyc = cyc;
          check("inhibit_len_ge_min", 32'(inh_len >= INH), 32'd1);
          check("rts_start_bit_driven", 32'(bus.ps2_dat_oe), 32'd1);
          inh_len = 0;
        end
        prev_oe = bus.ps2_clk_oe;
      end
    end
  end

  initial begin : result_monitor
    logic [1:0] got;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        got = {bus.tx_err, bus.tx_done};
        if (got != 2'b00) begin
          if (bus.tx_done) done_cnt++;
          if (bus.tx_err)  err_cnt++;
          if (res_q.size() == 0) check("unexpected_result", 32'(res_q.size()), 32'd1);
          else                   check("result", 32'(got), 32'(res_q.pop_front()));
          if (bus.tx_err)
            check("err_lines_released", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 32'd0);
          if (bus.tx_err && tmo_armed) begin
            check("timeout_latency", 32'(cyc - rts_cyc), 32'(TMO));
            tmo_seen = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~d;
    check("accept_ready_low", 32'(bus.tx_ready), 32'd0);
    check("accept_busy_high", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_complete(input string name);
    int n;
    n = 0;
    while ((res_q.size() != 0 || frame_q.size() != 0 || bus.tx_ready !== 1'b1) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completed_in_budget"}, 32'(n < 10000), 32'd1);
    repeat (50) @(negedge clk);
  endtask

  initial begin : stimulus
    int n;
    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_tx_ready", 32'(bus.tx_ready),   32'd1);
    check("rst_busy",     32'(bus.busy),       32'd0);
    check("rst_tx_done",  32'(bus.tx_done),    32'd0);
    check("rst_tx_err",   32'(bus.tx_err),     32'd0);
    check("rst_clk_oe",   32'(bus.ps2_clk_oe), 32'd0);
    check("rst_dat_oe",   32'(bus.ps2_dat_oe), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: 0xED, bits 1,0,1,1,0,1,1,1, parity 1, stop 1, ACK ok
    frame_q.push_back({1'b1, 1'b1, 8'hED});
    res_q.push_back(R_DONE);
    send(8'hED);
    wait_complete("t1_ed");
    check("t1_ready_back", 32'(bus.tx_ready), 32'd1);

    // 2: 0xF4, parity 0
    frame_q.push_back({1'b1, 1'b0, 8'hF4});
    res_q.push_back(R_DONE);
    send(8'hF4);
    wait_complete("t2_f4");

    // 3: 0xFF, device never acknowledges
    dev_mode = M_NO_ACK;
    frame_q.push_back({1'b1, 1'b1, 8'hFF});
    res_q.push_back(R_ERR);
    send(8'hFF);
    wait_complete("t3_ff_noack");
    dev_mode = M_NORMAL;

    // 4: 0x00, device never clocks -> timeout
    dev_mode  = M_SILENT;
    tmo_armed = 1'b1;
    tmo_seen  = 1'b0;
    res_q.push_back(R_ERR);
    send(8'h00);
    wait_complete("t4_timeout");
    check("t4_timeout_err_seen", 32'(tmo_seen), 32'd1);
    tmo_armed = 1'b0;
    dev_mode  = M_NORMAL;

    // 5: reset while d4 of 0x0F (d4 = 0, so data is pulled) is on the line
    send(8'h0F);
    n = 0;
    while (dev_fall_cnt != 5 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_bit4", 32'(n < 5000), 32'd1);
    repeat (20) @(negedge clk);
    check("t5_d4_driven_low", 32'(bus.ps2_dat_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
    check("t5_async_dat_oe", 32'(bus.ps2_dat_oe), 32'd0);
    check("t5_async_ready",  32'(bus.tx_ready),   32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    frame_q.push_back({1'b1, 1'b0, 8'hF4});
    res_q.push_back(R_DONE);
    send(8'hF4);
    wait_complete("t5_f4_after_rst");

    // 6: tx_valid with 0x55 while busy must be ignored
    frame_q.push_back({1'b1, 1'b1, 8'hED});
    res_q.push_back(R_DONE);
    send(8'hED);
    repeat (100) @(negedge clk);
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_complete("t6_ignore_busy");
    repeat (1500) @(negedge clk);

    check("total_tx_done", 32'(done_cnt), 32'd4);
    check("total_tx_err",  32'(err_cnt),  32'd2);
    check("frames_left",   32'(frame_q.size()), 32'd0);
    check("results_left",  32'(res_q.size()),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
